wb_multi_master_arbiter: RTL
============================

Name: wb_multi_master_arbiter

Overview:
- Parametrised successor to the single-core top-level bus hookup. Lets NUM_MASTERS Wishbone-classic masters share one processor-side core_* bus towards the Controller. Typical masters: a core's instruction bus, its data bus, and a debug/DMA port.
- Adds byte selects, fixed or round-robin arbitration, abort handling and an optional bus-timeout watchdog.

Parameters:
- NUM_MASTERS, 2, number of master ports (1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- PRIORITY_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles. Used only with the optional feature; must be ≥2.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- m_cyc_i  in  NUM_MASTERS  per-master cycle.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects, master i at slice i.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  addresses, master i at slice i.
- m_data_i  in  NUM_MASTERS*DATA_WIDTH  write data, master i at slice i.
- m_data_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master error (timeout).
- core_cyc  out  1  shared bus cycle.
- core_stb  out  1  shared bus strobe.
- core_we  out  1  shared bus write enable.
- core_sel  out  DATA_WIDTH/8  shared bus byte selects.
- core_addr  out  ADDR_WIDTH  shared bus address.
- core_data_out  out  DATA_WIDTH  shared bus write data.
- core_data_in  in  DATA_WIDTH  shared bus read data.
- core_ack  in  1  shared bus acknowledge.
- grant_o  out  NUM_MASTERS  one-hot current grant; all-zero when idle.

Behaviour:
- Reset: rst_n sampled low on a sys_clk edge forces the following.
  - state=IDLE, grant=0, timeout counter=0.
  - Round-robin pointer = NUM_MASTERS-1, so master 0 has first priority.
  - All outputs 0.
- Request: master i requests when m_cyc_i[i] & m_stb_i[i].
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise select a winner and register grant (one-hot).
    - Fixed mode: lowest requesting index wins.
    - Round-robin mode: first requester strictly after the pointer, wrapping modulo NUM_MASTERS.
  - Go to BUSY.
  - Latency: a request in cycle N gives core_cyc/core_stb=1 in cycle N+1.
- BUSY outputs:
  - core_cyc = core_stb = 1.
  - core_we, core_sel, core_addr and core_data_out are muxed combinationally from the granted master.
  - m_ack_o[g] = core_ack; m_data_o = core_data_in. All other m_ack_o bits are 0.
- BUSY transitions:
  - core_ack=1: go to IDLE next cycle. Round-robin pointer := g. grant clears.
  - Granted master drops m_cyc_i (abort), core_ack=0: go to IDLE next cycle. core_cyc drops in that next cycle. No ack is delivered. The pointer still updates to g.
  - Abort and core_ack in the same cycle: treat as a completed access; ack is passed through.
- Rearbitration: there is one idle cycle between back-to-back grants, so rearbitration happens at most once every 2 cycles.
- Bus protocol:
  - Single-access classic cycles only; no burst, no lock.
  - A master that keeps its request asserted after its ack re-competes in the next IDLE cycle.
- Idle outputs: m_data_o = 0 and core_* = 0.
- Width rules: slice i of a packed port is bits [(i+1)*W-1 : i*W].
- Corner case: with NUM_MASTERS=1 the design degenerates to a registered-request pass-through and behaves identically.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on entering BUSY and increments each BUSY cycle without core_ack.
  - If the counter equals TIMEOUT_CYCLES-1 with core_ack=0, assert m_err_o[g] for exactly that cycle and go to IDLE next cycle.
  - m_ack_o[g] stays 0 for a timed-out access.
  - A core_ack arriving in the same cycle wins; no error is raised.
- Not defined: no counter logic; m_err_o is tied to 0; an unacknowledged access holds BUSY indefinitely.

Test Plan:
1. Reset, then master 0 reads addr 0x100, sel 0xF; slave acks 3 cycles after stb with data 0xDEADBEEF -> core_stb rises 1 cycle after request; m_ack_o=01 for one cycle with m_data_o=0xDEADBEEF; grant_o returns to 00.
2. PRIORITY_MODE=0, both masters request continuously, slave acks immediately -> grant_o sequence is 01,00,01,00…; master 1 is never served.
3. PRIORITY_MODE=1, same stimulus -> grant_o sequence is 01,00,10,00,01…; each master is served every 4 cycles.
4. Master 1 writes 0x12345678 to 0x2000 with sel 0x3 -> core_we=1, core_sel=0x3, core_addr=0x2000, core_data_out=0x12345678 while grant_o=10.
5. Master 0 drops m_cyc_i after 2 BUSY cycles, no ack given -> core_cyc=0 the next cycle; no m_ack_o pulse. Then rst_n=0 held for 1 cycle during a BUSY access -> all outputs are 0 on the next edge.
6. WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks -> m_err_o[0] pulses in the 8th BUSY cycle; IDLE on the next cycle. Without the macro, BUSY persists with m_err_o=0.

Source files
------------

// File: rtl/wb_multi_master_arbiter.sv
// Shares one Wishbone-classic core_* bus among NUM_MASTERS masters; grant registered (request N -> core_stb N+1), one idle cycle between grants.
// A granted master is held until core_ack, abort (m_cyc_i drop) or, with WB_ARB_TIMEOUT_EN defined, the TIMEOUT_CYCLES watchdog.
module wb_multi_master_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  sys_clk,
    input  logic                                  rst_n,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_data_i,
    output logic [DATA_WIDTH-1:0]                 m_data_o,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic                                  core_cyc,
    output logic                                  core_stb,
    output logic                                  core_we,
    output logic [DATA_WIDTH/8-1:0]               core_sel,
    output logic [ADDR_WIDTH-1:0]                 core_addr,
    output logic [DATA_WIDTH-1:0]                 core_data_out,
    input  logic [DATA_WIDTH-1:0]                 core_data_in,
    input  logic                                  core_ack,
    output logic [NUM_MASTERS-1:0]                grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_multi_master_arbiter: NUM_MASTERS must be 1..8");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("wb_multi_master_arbiter: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_multi_master_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_rr_ptr_nxt;
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_winner;
    logic [PTR_W-1:0]       w_gnt_idx;
    int                     w_gnt_int;
    logic                   w_busy;
    logic                   w_gnt_cyc;
    logic                   w_timeout;

    assign w_req     = m_cyc_i & m_stb_i;
    assign w_busy    = (r_state == ST_BUSY);
    assign w_gnt_int = int'(w_gnt_idx);
    assign w_gnt_cyc = m_cyc_i[w_gnt_idx];

    // Round-robin searches from the slot just after the last served master.
    always_comb begin
        int idx;
        w_winner = '0;
        idx      = 0;
        if (PRIORITY_MODE == 1) begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                idx = (int'(r_rr_ptr) + k) % NUM_MASTERS;
                if (w_req[idx] && (w_winner == '0)) begin
                    w_winner[idx] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_req[i] && (w_winner == '0)) begin
                    w_winner[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_gnt_idx = PTR_W'(i);
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_to_cnt;

    // Held at zero while idle, so every access starts counting from zero.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_busy) begin
            r_to_cnt <= '0;
        end else if (!core_ack) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = w_busy && !core_ack && (r_to_cnt == CNT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= PTR_W'(NUM_MASTERS - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_winner;
                end
            end
            ST_BUSY: begin
                // Ack wins over a simultaneous abort; all three end the access.
                if (core_ack || !w_gnt_cyc || w_timeout) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_gnt_idx;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        core_cyc      = 1'b0;
        core_stb      = 1'b0;
        core_we       = 1'b0;
        core_sel      = '0;
        core_addr     = '0;
        core_data_out = '0;
        m_data_o      = '0;
        m_ack_o       = '0;
        m_err_o       = '0;
        if (w_busy) begin
            core_cyc      = 1'b1;
            core_stb      = 1'b1;
            core_we       = m_we_i[w_gnt_idx];
            core_sel      = m_sel_i[w_gnt_int*SEL_WIDTH +: SEL_WIDTH];
            core_addr     = m_addr_i[w_gnt_int*ADDR_WIDTH +: ADDR_WIDTH];
            core_data_out = m_data_i[w_gnt_int*DATA_WIDTH +: DATA_WIDTH];
            m_data_o      = core_data_in;
            m_ack_o       = r_grant & {NUM_MASTERS{core_ack}};
            m_err_o       = r_grant & {NUM_MASTERS{w_timeout}};
        end
    end

    assign grant_o = r_grant;

endmodule
